cg_enable_ctrl: RTL and testbench
=================================

Name: cg_enable_ctrl

Overview:
- Activity-driven clock-gate enable controller; sits directly upstream of the enable-gated register stage.
- Drives that stage's enable (cg_en) and back-pressures the producer while the stage is gated or waking.
- Gates after a programmable run of idle cycles; wakes on new request or force_on with a fixed wake latency.

Parameters:
IDLE_W, 8, width of idle threshold and idle counter
WAKE_CYC, 2, cycles spent in WAKE before accepting data; legal range >= 1
STAT_W, 32, width of gated-cycle statistic counter (used only with CG_STATS_EN)

Ports:
clk  input  1  single clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  producer has data for the gated stage
req_ready  output  1  producer may transfer; transfer = req_valid & req_ready
force_on  input  1  keep or return the stage clocked regardless of activity
idle_thresh  input  IDLE_W  consecutive idle cycles before gating; 0 disables gating
cg_en  output  1  enable to the gated stage or ICG
gated  output  1  status: stage currently gated
wake_evt  output  1  one-cycle pulse on the first WAKE cycle
gated_cycles  output  STAT_W  cycles spent in GATED; present only with CG_STATS_EN

Behaviour:
- Reset is asynchronous and active-high, per the already-decided interface. On reset: state=RUN, idle_cnt=0, wake_cnt=0, cg_en=1, req_ready=1, gated=0, wake_evt=0, gated_cycles=0.
- All outputs are decoded from registered state. There is no combinational path from any input to any output.
- States: RUN, GATED, WAKE.
- RUN:
  - Outputs: cg_en=1, req_ready=1, gated=0.
  - An idle cycle is one with req_valid=0 and force_on=0. Each idle cycle increments idle_cnt; a non-idle cycle clears idle_cnt to 0.
  - If idle_thresh!=0, the cycle is idle, and idle_cnt+1 >= idle_thresh: next state is GATED and idle_cnt clears.
  - The >= comparison is live, so lowering idle_thresh mid-count gates on the next idle cycle.
  - idle_cnt never wraps: it stops at the threshold and holds at max when idle_thresh=0.
- GATED:
  - Outputs: cg_en=0, req_ready=0, gated=1.
  - req_valid=1 or force_on=1: next state is WAKE, wake_cnt=0, wake_evt=1 for that first WAKE cycle only.
- WAKE:
  - Outputs: cg_en=1 (clock restored before data arrives), req_ready=0, gated=0.
  - wake_cnt increments each cycle; at wake_cnt==WAKE_CYC-1 the next state is RUN.
  - Inputs are ignored in WAKE. If req_valid drops, WAKE still completes to RUN and idle counting restarts from 0.
- Latency: req_valid sampled high in GATED at cycle t gives req_ready=1 at cycle t+1+WAKE_CYC. Producer holds req_valid and data until the transfer.
- Simultaneous events:
  - RUN: req_valid or force_on in the would-be threshold cycle keeps RUN.
  - GATED: req_valid and force_on together behave as a single wake.
- Reset mid-operation: any state returns immediately to RUN with cg_en=1.

Optional Feature:
- Macro: CG_STATS_EN.
- Defined: gated_cycles port exists; it increments every cycle in GATED, saturates at all-ones, and is cleared only by reset.
- Undefined: the port and the counter are absent and there is no other behavioural change.

Decomposition:
- Package cg_pkg:
  - typedef enum cg_state_t {CG_RUN, CG_GATED, CG_WAKE}
  - default localparams CG_IDLE_W=8, CG_WAKE_CYC=2
- Sub-module: cg_idle_counter (IDLE_W counter with clear, increment, threshold compare; outputs hit).
- FSM, wake counter and stats stay in the top level.

Test Plan:
- Reset with req_valid=0 and idle_thresh=4 -> cg_en=1 and req_ready=1 after reset; gated=1 exactly 4 cycles after reset deassert.
- From GATED, pulse req_valid at cycle t with WAKE_CYC=2 -> wake_evt=1 at t+1, cg_en=1 from t+1, req_ready=1 at t+3; no transfer before t+3.
- idle_thresh=3, req_valid toggles 0,0,1,0,0,1 in RUN -> never gates; idle_cnt is cleared on each req_valid.
- idle_thresh=0 for 500 idle cycles -> remains RUN, cg_en=1 throughout; force_on in GATED -> WAKE then RUN.
- Assert reset during cycle 1 of WAKE -> next cycle RUN, cg_en=1, req_ready=1, gated=0, wake_evt=0.
- CG_STATS_EN defined, STAT_W=4, 20 cycles GATED -> gated_cycles saturates at 15; undefined -> elaboration has no gated_cycles port.

Source files
------------

// File: rtl/cg_pkg.sv
// cg_pkg: shared types and defaults for the clock-gate enable controller.
//   cg_state_t  : controller state encoding (RUN, GATED, WAKE)
//   CG_IDLE_W   : default width of the idle threshold / idle counter
//   CG_WAKE_CYC : default number of cycles spent in WAKE
package cg_pkg;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_GATED = 2'd1,
    CG_WAKE  = 2'd2
  } cg_state_t;

  localparam int CG_IDLE_W   = 8;
  localparam int CG_WAKE_CYC = 2;

endpackage

// File: rtl/cg_idle_counter.sv
// cg_idle_counter: counts consecutive idle cycles and flags when the run of
// idle cycles reaches the programmed threshold.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : clear the count (non-idle cycle, or controller not in RUN)
//   inc        : this cycle is an idle RUN cycle
//   thresh     : idle threshold; 0 disables the hit
//   hit        : this idle cycle completes the threshold run (count clears)
module cg_idle_counter
  import cg_pkg::*;
#(
  parameter int IDLE_W = CG_IDLE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic [IDLE_W-1:0] thresh,
  output logic              hit
);

  logic [IDLE_W-1:0] cnt;
  logic [IDLE_W:0]   cnt_p1;

  // One bit wider so the compare stays correct when cnt is saturated.
  assign cnt_p1 = {1'b0, cnt} + {{IDLE_W{1'b0}}, 1'b1};

  // Live compare: lowering thresh below the current count hits on the
  // very next idle cycle.
  assign hit = inc && (thresh != '0) && (cnt_p1 >= {1'b0, thresh});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || hit) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      // Saturates at all-ones (only reachable with thresh == 0).
      cnt <= cnt_p1[IDLE_W-1:0];
    end
  end

endmodule

// File: rtl/cg_enable_ctrl.sv
// cg_enable_ctrl: activity-driven clock-gate enable controller for the
// enable-gated register stage directly downstream of the producer.
// Optional feature macro: CG_STATS_EN (adds the gated_cycles statistic).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   req_valid    : producer has data for the gated stage
//   req_ready    : producer may transfer
//   force_on     : keep / return the stage clocked regardless of activity
//   idle_thresh  : consecutive idle cycles before gating; 0 never gates
//   cg_en        : enable to the gated stage / ICG
//   gated        : stage currently gated
//   wake_evt     : one-cycle pulse on the first WAKE cycle
//   state_dbg    : current controller state, for observation only
//   gated_cycles : saturating count of GATED cycles (CG_STATS_EN only)
//
// Handshake: a transfer happens on a rising clk edge where
// req_valid & req_ready are both 1. req_ready is high only in RUN, so the
// producer sees it deasserted while gated or waking and must hold
// req_valid and its data stable until the transfer.
module cg_enable_ctrl
  import cg_pkg::*;
#(
  parameter int IDLE_W   = CG_IDLE_W,
  parameter int WAKE_CYC = CG_WAKE_CYC,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              force_on,
  input  logic [IDLE_W-1:0] idle_thresh,
  output logic              cg_en,
  output logic              gated,
  output logic              wake_evt,
  output cg_state_t         state_dbg
`ifdef CG_STATS_EN
  ,
  output logic [STAT_W-1:0] gated_cycles
`endif
);

  localparam int WAKE_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);

  cg_state_t         state;
  cg_state_t         state_nxt;
  logic [WAKE_W-1:0] wake_cnt;
  logic              idle;
  logic              idle_hit;

  assign idle = !req_valid && !force_on;

  cg_idle_counter #(
    .IDLE_W (IDLE_W)
  ) u_idle_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    ((state != CG_RUN) || !idle),
    .inc    ((state == CG_RUN) && idle),
    .thresh (idle_thresh),
    .hit    (idle_hit)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      CG_RUN:   if (idle_hit) state_nxt = CG_GATED;
      CG_GATED: if (req_valid || force_on) state_nxt = CG_WAKE;
      // Inputs are ignored while waking; WAKE always runs to completion.
      CG_WAKE:  if (wake_cnt == WAKE_LAST) state_nxt = CG_RUN;
      default:  state_nxt = CG_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CG_RUN;
      wake_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Zero on entry to WAKE, so the first WAKE cycle sees wake_cnt == 0.
      if ((state == CG_WAKE) && (wake_cnt != WAKE_LAST)) begin
        wake_cnt <= wake_cnt + WAKE_W'(1);
      end else begin
        wake_cnt <= '0;
      end
    end
  end

  // Every output is a decode of registered state only.
  assign cg_en     = (state != CG_GATED);
  assign req_ready = (state == CG_RUN);
  assign gated     = (state == CG_GATED);
  assign wake_evt  = (state == CG_WAKE) && (wake_cnt == '0);
  assign state_dbg = state;

`ifdef CG_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gated_cycles <= '0;
    end else if ((state == CG_GATED) && (gated_cycles != '1)) begin
      gated_cycles <= gated_cycles + STAT_W'(1);
    end
  end
`else
  logic stat_unused;
  assign stat_unused = (STAT_W > 0);
`endif

endmodule

// File: tb/tb_cg_enable_ctrl.sv
module tb_cg_enable_ctrl;
  import cg_pkg::*;

  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;
  localparam int STAT_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              force_on;
  logic [IDLE_W-1:0] idle_thresh;
  logic              cg_en;
  logic              gated;
  logic              wake_evt;
  cg_state_t         state_dbg;
`ifdef CG_STATS_EN
  logic [STAT_W-1:0] gated_cycles;
`endif

  cg_enable_ctrl #(
    .IDLE_W   (IDLE_W),
    .WAKE_CYC (WAKE_CYC),
    .STAT_W   (STAT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .force_on     (force_on),
    .idle_thresh  (idle_thresh),
    .cg_en        (cg_en),
    .gated        (gated),
    .wake_evt     (wake_evt),
    .state_dbg    (state_dbg)
`ifdef CG_STATS_EN
    ,
    .gated_cycles (gated_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  // Expected output vector: {cg_en, req_ready, gated, wake_evt}
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  // ---------------- driver helpers ----------------
  // Advance one clock and sample the outputs 1 time unit after the edge.
  task automatic sample(output logic [3:0] obs);
    @(posedge clk);
    #1;
    obs = {cg_en, req_ready, gated, wake_evt};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] expv [5] = '{4'b1100, 4'b1100, 4'b1100, 4'b0010, 4'b0010};
    logic [3:0] obs, e;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(4'b1100);
    obs = {cg_en, req_ready, gated, wake_evt};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b expected %b", obs, e);
    end
    n_checks++;
    if (state_dbg !== CG_RUN) begin
      n_fails++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, CG_RUN);
    end
    reset = 1'b0;
    foreach (expv[i]) exp_q.push_back(expv[i]);
    for (int i = 0; i < 5; i++) begin
      sample(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL reset_to_gate cycle %0d: got %b expected %b", i + 1, obs, e);
      end
    end
  endtask

  // Entered in GATED: req_valid at cycle t -> evt at t+1, ready at t+3.
  task automatic test_wake();
    logic [3:0] expv [3] = '{4'b1001, 4'b1000, 4'b1100};
    logic [3:0] obs, e;
    foreach (expv[i]) exp_q.push_back(expv[i]);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL wake_latency t+%0d: got %b expected %b", i + 1, obs, e);
      end
    end
  endtask

  task automatic test_idle_toggle();
    logic       rv   [15] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    logic [3:0] expv [15] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
                              4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
                              4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0010};
    logic [3:0] obs, e;
    idle_thresh = 8'd3;
    foreach (expv[i]) exp_q.push_back(expv[i]);
    for (int i = 0; i < 15; i++) begin
      req_valid = rv[i];
      sample(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL idle_toggle step %0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

  // Entered in GATED, thresh=3: force_on wake, would-be-threshold keep,
  // and req_valid+force_on together as a single wake.
  task automatic test_force_on();
    logic [1:0] stim [13] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00,
                              2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
    logic [3:0] expv [13] = '{4'b1001, 4'b1000, 4'b1100, 4'b1100, 4'b1100,
                              4'b1100, 4'b1100, 4'b1100, 4'b0010, 4'b1001,
                              4'b1000, 4'b1100, 4'b1100};
    logic [3:0] obs, e;
    foreach (expv[i]) exp_q.push_back(expv[i]);
    for (int i = 0; i < 13; i++) begin
      {req_valid, force_on} = stim[i];
      sample(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL force_on step %0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

  // thresh=0 never gates; then lowering thresh gates on the next idle cycle.
  task automatic test_no_gate();
    logic [1:0] stim [4] = '{2'b00, 2'b10, 2'b10, 2'b10};
    logic [3:0] expv [4] = '{4'b0010, 4'b1001, 4'b1000, 4'b1100};
    logic [3:0] obs, e;
    int bad;
    bad = 0;
    idle_thresh = 8'd0;
    req_valid = 1'b0;
    force_on  = 1'b0;
    for (int i = 0; i < 500; i++) begin
      sample(obs);
      if (obs !== 4'b1100) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fails++;
      $display("FAIL no_gate: got %0d bad cycles expected 0", bad);
    end
    idle_thresh = 8'd5;
    foreach (expv[i]) exp_q.push_back(expv[i]);
    for (int i = 0; i < 4; i++) begin
      {req_valid, force_on} = stim[i];
      sample(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL live_thresh step %0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_in_wake();
    logic       rv   [3] = '{0, 0, 1};
    logic [3:0] expv [7] = '{4'b1100, 4'b0010, 4'b1001,
                             4'b1100, 4'b1100, 4'b1100, 4'b0010};
    logic [3:0] obs, e;
    idle_thresh = 8'd2;
    foreach (expv[i]) exp_q.push_back(expv[i]);
    for (int i = 0; i < 3; i++) begin
      req_valid = rv[i];
      sample(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL rst_wake setup %0d: got %b expected %b", i, obs, e);
      end
    end
    // Now in the first WAKE cycle: reset acts without waiting for an edge.
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    obs = {cg_en, req_ready, gated, wake_evt};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("FAIL rst_wake async: got %b expected %b", obs, e);
    end
    for (int i = 0; i < 3; i++) begin
      sample(obs);
      if (i == 0) reset = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL rst_wake after %0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

`ifdef CG_STATS_EN
  task automatic test_stats();
    logic [3:0] obs;
    reset = 1'b1;
    req_valid = 1'b0;
    force_on = 1'b0;
    idle_thresh = 8'd2;
    sample(obs);
    reset = 1'b0;
    n_checks++;
    if (gated_cycles !== 4'd0) begin
      n_fails++;
      $display("FAIL stats_reset: got %0d expected 0", gated_cycles);
    end
    repeat (2) sample(obs);
    n_checks++;
    if (obs !== 4'b0010 || gated_cycles !== 4'd0) begin
      n_fails++;
      $display("FAIL stats_enter: got %b/%0d expected 0010/0", obs, gated_cycles);
    end
    repeat (5) sample(obs);
    n_checks++;
    if (gated_cycles !== 4'd5) begin
      n_fails++;
      $display("FAIL stats_count: got %0d expected 5", gated_cycles);
    end
    repeat (15) sample(obs);
    n_checks++;
    if (gated_cycles !== 4'd15) begin
      n_fails++;
      $display("FAIL stats_saturate: got %0d expected 15", gated_cycles);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    force_on    = 1'b0;
    idle_thresh = 8'd4;
    test_reset();
    test_wake();
    test_idle_toggle();
    test_force_on();
    test_no_gate();
    test_reset_in_wake();
`ifdef CG_STATS_EN
    test_stats();
`endif
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
